// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, opcodes,
// datapath select encodings and the control word produced by the decoder.
package mc_ctrl_pkg;

  // State codes (4 bits; one encoding is left unused and recovers to HALT)
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
  localparam logic [3:0] ST_JALRLINK = 4'd11;
  localparam logic [3:0] ST_JALR     = 4'd12;
  localparam logic [3:0] ST_LUI      = 4'd13;
  localparam logic [3:0] ST_HALT     = 4'd14;

  typedef enum logic [3:0] {
    FETCH    = ST_FETCH,
    DECODE   = ST_DECODE,
    MEMADR   = ST_MEMADR,
    MEMREAD  = ST_MEMREAD,
    MEMWB    = ST_MEMWB,
    MEMWRITE = ST_MEMWRITE,
    EXECR    = ST_EXECR,
    EXECI    = ST_EXECI,
    ALUWB    = ST_ALUWB,
    BRANCH   = ST_BRANCH,
    JAL      = ST_JAL,
    JALRLINK = ST_JALRLINK,
    JALR     = ST_JALR,
    LUI      = ST_LUI,
    HALT     = ST_HALT
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALU operand muxes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ALU decoder hint
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Raw per-state control word; the top applies the mem_ready / branch_taken gating.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       fetch;         // IRWrite and PCUpdate follow mem_ready
    logic       pc_update;     // unconditional PC load
    logic       branch;        // PC load qualified by branch_taken
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       instr_done;    // unconditional retire pulse
    logic       done_on_ready; // retire pulse qualified by mem_ready
    logic       illegal;
  } ctrl_t;

  // Immediate format implied by the opcode (R-type has none, I is harmless)
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_B:    imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      OP_LUI:  imm_src_of = IMM_U;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode for the multicycle controller.
module mc_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  // Moore decode: every field defaults to 0 and each state sets only what it drives
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.fetch      = 1'b1;
      end
      DECODE: begin
        // Branch/jump target OldPC+imm lands in ALUOut for later use
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = imm_src_of(op);
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = imm_src_of(op);
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_req       = 1'b1;
        ctrl.adr_src       = 1'b1;
        ctrl.mem_write     = 1'b1;
        ctrl.done_on_ready = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.imm_src   = IMM_I;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_BR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JAL: begin
        // PC <- target held in ALUOut while the ALU forms OldPC+4 for the link
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      JALRLINK: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.reg_write  = 1'b1;
      end
      JALR: begin
        // Register A was latched in DECODE, so rd == rs1 is harmless here
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_ALURES;
        ctrl.pc_update  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      LUI: begin
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMM;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      HALT: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main Moore controller for the multicycle RV32I core: state register,
// next-state logic and the handshake/branch gating of the decoded control word.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  state_t state_reg, state_next;
  ctrl_t  dec_ctrl, ctrl;

  mc_outdec u_outdec (
    .state (state_reg),
    .op    (op),
    .ctrl  (dec_ctrl)
  );

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= FETCH;
    else          state_reg <= state_next;
  end

  // Next-state logic; stray encodings fall into HALT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_B:         state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          OP_JALR:      state_next = JALRLINK;
          OP_LUI:       state_next = LUI;
          default:      state_next = HALT;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
      JALRLINK: state_next = JALR;
      JALR:     state_next = FETCH;
      LUI:      state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = HALT;
    endcase
  end

  // While reset is held every output is forced low so no write can slip out
  always_comb begin
    ctrl = reset_n ? dec_ctrl : '0;
  end

  // Output gating: fetch handshake, branch resolution and store completion
  always_comb begin
    mem_req    = ctrl.mem_req;
    AdrSrc     = ctrl.adr_src;
    MemWrite   = ctrl.mem_write;
    IRWrite    = ctrl.fetch & mem_ready;
    PCWrite    = ctrl.pc_update | (ctrl.fetch & mem_ready) | (ctrl.branch & branch_taken);
    RegWrite   = ctrl.reg_write;
    ResultSrc  = ctrl.result_src;
    ALUSrcA    = ctrl.alu_src_a;
    ALUSrcB    = ctrl.alu_src_b;
    ALUOp      = ctrl.alu_op;
    ImmSrc     = ctrl.imm_src;
    instr_done = ctrl.instr_done | (ctrl.done_on_ready & mem_ready);
    illegal    = ctrl.illegal;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: randomized instruction stream with
// random memory stalls, checked per instruction against a cost/effect model.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] C_LW   = 7'b0000011;
  localparam logic [6:0] C_SW   = 7'b0100011;
  localparam logic [6:0] C_R    = 7'b0110011;
  localparam logic [6:0] C_B    = 7'b1100011;
  localparam logic [6:0] C_I    = 7'b0010011;
  localparam logic [6:0] C_JALR = 7'b1100111;
  localparam logic [6:0] C_JAL  = 7'b1101111;
  localparam logic [6:0] C_LUI  = 7'b0110111;

  logic       clk, reset_n, branch_taken, mem_ready;
  logic [6:0] op;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       instr_done, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal};
  endfunction

  // One instruction from its first FETCH cycle to its retire pulse.
  // dwait < 0: random stalls; otherwise fetch is immediate and the data access waits dwait cycles.
  task automatic run_instr(input logic [6:0] o, input bit taken, input int dwait);
    bit rdy[64];
    int f, m, e_cyc, e_req, e_mw, e_rw, e_pcw;
    logic [1:0] e_rs, e_rw_a, e_a_last, e_b_last;
    bit e_pcw_last;
    int cyc, req, mw, rw, pcw, irw;
    logic [1:0] rs, rw_a, a_last, b_last;
    bit pcw_last, done;
    for (int k = 0; k < 64; k++) begin
      if (dwait >= 0) rdy[k] = !(k >= 3 && k < 3 + dwait);
      else            rdy[k] = (k >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    // Fetch occupies indices 0..f, decode f+1, address f+2, data access from f+3
    f = 0; while (!rdy[f]) f++;
    m = 0; while (!rdy[f + 3 + m]) m++;
    e_req = f + 1; e_mw = 0; e_rw = 0; e_pcw = 1; e_rs = 2'b00; e_rw_a = 2'b00;
    e_a_last = 2'b00; e_b_last = 2'b00; e_pcw_last = 1'b0;
    case (o)
      C_LW:   begin e_cyc = f + m + 5; e_req = f + m + 2; e_rw = 1; e_rs = 2'b01; end
      C_SW:   begin e_cyc = f + m + 4; e_req = f + m + 2; e_mw = m + 1; end
      C_R, C_I: begin e_cyc = f + 4; e_rw = 1; e_rs = 2'b00; end
      C_B:    begin e_cyc = f + 3; e_pcw = 1 + int'(taken); e_a_last = 2'b10; e_pcw_last = taken; end
      C_JAL:  begin e_cyc = f + 4; e_rw = 1; e_rs = 2'b00; e_pcw = 2; end
      C_JALR: begin e_cyc = f + 4; e_rw = 1; e_rs = 2'b10; e_rw_a = 2'b01; e_pcw = 2;
                    e_a_last = 2'b10; e_b_last = 2'b01; e_pcw_last = 1'b1; end
      default: begin e_cyc = f + 3; e_rw = 1; e_rs = 2'b11; end // lui
    endcase
    cyc = 0; req = 0; mw = 0; rw = 0; pcw = 0; irw = 0; done = 0;
    rs = 2'b00; rw_a = 2'b00; a_last = 2'b00; b_last = 2'b00; pcw_last = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin op = o; branch_taken = taken; end
      mem_ready = rdy[k];
      #1;
      req += int'(mem_req); mw += int'(MemWrite); pcw += int'(PCWrite); irw += int'(IRWrite);
      if (RegWrite) begin rw++; rs = ResultSrc; rw_a = ALUSrcA; end
      if (instr_done) begin
        done = 1; cyc = k + 1; a_last = ALUSrcA; b_last = ALUSrcB; pcw_last = PCWrite;
      end
    end
    $display("instr op=%b taken=%0d fetch_wait=%0d data_wait=%0d cycles=%0d (model %0d)",
             o, taken, f, m, cyc, e_cyc);
    check("cycles", cyc, e_cyc);
    check("mem_req_cycles", req, e_req);
    check("memwrite_cycles", mw, e_mw);
    check("regwrite_cycles", rw, e_rw);
    check("pcwrite_cycles", pcw, e_pcw);
    check("irwrite_cycles", irw, 1);
    if (e_rw != 0) begin
      check("resultsrc_at_wb", rs, e_rs);
      check("alusrca_at_wb", rw_a, e_rw_a);
    end
    check("last_cycle_src", {a_last, b_last}, {e_a_last, e_b_last});
    check("last_cycle_pcwrite", pcw_last, e_pcw_last);
  endtask

  initial begin
    logic [6:0] ops [8];
    int bad, hcyc, f;
    bit seen;
    ops = '{C_LW, C_SW, C_R, C_B, C_I, C_JALR, C_JAL, C_LUI};
    reset_n = 1'b0; mem_ready = 1'b0; op = 7'd0; branch_taken = 1'b0;

    // Reset: every output low while reset_n is held
    repeat (3) @(negedge clk);
    mem_ready = 1'b1; #1;
    check("reset_outputs", all_outs(), 19'd0);
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b0; #1;
    $display("reset released: mem_req=%0d ALUSrcB=%0d ResultSrc=%0d", mem_req, ALUSrcB, ResultSrc);
    check("fetch_after_reset", {mem_req, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10});

    // Directed: stall-free lw, sw with a 3-cycle store stall, taken/not-taken branch, jalr
    run_instr(C_LW, 1'b0, 0);
    run_instr(C_SW, 1'b0, 3);
    run_instr(C_B, 1'b1, 0);
    run_instr(C_B, 1'b0, 0);
    run_instr(C_JALR, 1'b0, 0);

    // Random stream with random stalls
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), -1);

    // Illegal opcode: HALT is reached and held
    seen = 0; hcyc = 0;
    f = $urandom_range(0, 3);
    for (int k = 0; k < 32 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) op = 7'b1111111;
      mem_ready = (k >= f);
      #1;
      if (illegal) begin seen = 1; hcyc = k + 1; end
    end
    $display("illegal op: halt after %0d cycles (model %0d)", hcyc, f + 3);
    check("halt_entry_cycles", hcyc, f + 3);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
      #1;
      if (all_outs() !== 19'd1) bad++;
    end
    check("halt_sticky_bad_cycles", bad, 0);
    @(negedge clk);
    reset_n = 1'b0; #1;
    check("halt_reset_outputs", all_outs(), 19'd0);
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b0; #1;
    check("halt_exit_fetch", {mem_req, illegal, ALUSrcB}, {1'b1, 1'b0, 2'b10});

    // Reset in the middle of a stalled store
    @(negedge clk); op = C_SW; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    check("store_active", {mem_req, AdrSrc, MemWrite}, 3'b111);
    #2 reset_n = 1'b0; #1;
    check("store_killed", {mem_req, MemWrite, RegWrite, PCWrite, instr_done}, 5'd0);
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b0; #1;
    check("fetch_after_kill", {mem_req, AdrSrc, MemWrite, ALUSrcB}, {3'b100, 2'b10});
    run_instr(C_LUI, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
